// File: rtl/resc_pkg.sv
// Shared constants for the programmable ReSC stream engine: LFSR taps, seeds, FSM states.
package resc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   // Seeds are truncated to the LFSR width; the low six bits of the first
   // three are chosen to be far apart in the 6-bit sequence to limit correlation.
   localparam logic [7:0][15:0] X_SEED = {
      16'h2A5F, 16'h9D36, 16'h4E6C, 16'h7B92,
      16'h1F27, 16'h3CB3, 16'h5A6A, 16'hACC1
   };
   localparam logic [15:0] C_SEED = 16'h3A95;

   // Maximal-length Fibonacci tap masks (bit t-1 set for tap t).
   function automatic logic [15:0] taps(input int w);
      case (w)
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0829;
         13:      taps = 16'h100D;
         14:      taps = 16'h2015;
         15:      taps = 16'h6000;
         default: taps = 16'hD008;
      endcase
   endfunction

endpackage

// File: rtl/resc_lfsr.sv
// Fibonacci LFSR with seed load and step enable; load wins over step.
module resc_lfsr
   import resc_pkg::*;
#(
   parameter int          W    = 6,
   parameter logic [15:0] SEED = 16'h0001
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   output logic [W-1:0] state
);

   localparam logic [15:0]  TAP16  = taps(W);
   localparam logic [W-1:0] TAPS   = TAP16[W-1:0];
   // A seed that truncates to zero would lock the register, so fall back to 1.
   localparam logic [W-1:0] SEED_T = SEED[W-1:0];
   localparam logic [W-1:0] SEED_W = (SEED_T == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED_T;

   logic fb;
   assign fb = ^(state & TAPS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     state <= SEED_W;
      else if (load)  state <= SEED_W;
      else if (step)  state <= {state[W-2:0], fb};
   end

endmodule

// File: rtl/resc_prog_stream_engine.sv
// Stochastic Bernstein-polynomial evaluator with run-time coefficients and start/done handshake.
module resc_prog_stream_engine
   import resc_pkg::*;
#(
   parameter int X_WIDTH = 6,
   parameter int Y_WIDTH = 10,
   parameter int DEGREE  = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [X_WIDTH-1:0]              x_bin,
   input  logic [(DEGREE+1)*Y_WIDTH-1:0]   coef_bin,
   output logic                            busy,
   output logic                            done,
   output logic [Y_WIDTH-1:0]              y_bin
);

   localparam int SEL_W = $clog2(DEGREE + 1);
   localparam logic [Y_WIDTH-1:0] LAST_CNT = {{(Y_WIDTH-1){1'b1}}, 1'b0};

   fsm_t                              state;
   logic [X_WIDTH-1:0]                x_lat;
   logic [DEGREE:0][Y_WIDTH-1:0]      coef_lat;
   logic [Y_WIDTH-1:0]                acc;
   logic [Y_WIDTH-1:0]                cnt;

   logic                              lfsr_load;
   logic                              lfsr_step;
   logic [DEGREE-1:0][X_WIDTH-1:0]    rx;
   logic [Y_WIDTH-1:0]                rc;
   logic [DEGREE-1:0]                 xs;
   logic [DEGREE:0]                   zs;
   logic [SEL_W-1:0]                  sel;
   logic                              stream_bit;

   assign lfsr_load = (state == IDLE) && start;
   assign lfsr_step = (state == RUN);

   for (genvar g = 0; g < DEGREE; g++) begin : g_x
      resc_lfsr #(.W(X_WIDTH), .SEED(X_SEED[g])) u_x_lfsr (
         .clk   (clk),
         .reset (reset),
         .load  (lfsr_load),
         .step  (lfsr_step),
         .state (rx[g])
      );
      assign xs[g] = (x_lat >= rx[g]);
   end

   resc_lfsr #(.W(Y_WIDTH), .SEED(C_SEED)) u_c_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .state (rc)
   );

   for (genvar k = 0; k <= DEGREE; k++) begin : g_z
      assign zs[k] = (coef_lat[k] >= rc);
   end

   // Popcount of the x streams picks which coefficient stream feeds the output.
   always_comb begin
      sel = '0;
      for (int i = 0; i < DEGREE; i++) sel = sel + SEL_W'(xs[i]);
      stream_bit = 1'b0;
      for (int k = 0; k <= DEGREE; k++)
         if (sel == SEL_W'(k)) stream_bit = zs[k];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         y_bin    <= '0;
         acc      <= '0;
         cnt      <= '0;
         x_lat    <= '0;
         coef_lat <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  x_lat    <= x_bin;
                  coef_lat <= coef_bin;
                  acc      <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc + {{(Y_WIDTH-1){1'b0}}, stream_bit};
               cnt <= cnt + 1'b1;
               // One full coef-LFSR period visits every nonzero rc exactly once.
               if (cnt == LAST_CNT) begin
                  y_bin <= acc + {{(Y_WIDTH-1){1'b0}}, stream_bit};
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
